rtc_bus_scheduler: RTL and testbench
====================================

Name: rtc_bus_scheduler

Overview:
- Sequencer and arbiter in front of the signals_rtc bus-signal generator.
- Turns two requesters into atomic address-phase/data-phase transaction pairs on the multiplexed RTC A/D bus:
  - an internal periodic time-refresh engine, which burst-reads the seconds, minutes and hours registers;
  - a user write port.
- Drives signals_rtc's EN_signals/read/dato controls and the 8-bit bus value.
- Captures read data into time registers for the display path.

Parameters:
PHASE_CYCLES, 32, clocks per bus phase; matches one signals_rtc CS/WR/RD/AD pulse frame (320 ns at 100 MHz)
GAP_CYCLES, 4, idle clocks with EN_signals=0 between transactions
REFRESH_CYCLES, 1000, clocks between refresh requests; must be greater than 0
READ_BASE_ADDR, 8'h21, address of the seconds register; minutes = +1, hours = +2
INIT_ADDR, 8'h02, init write address (optional feature only)
INIT_DATA, 8'h10, init write data (optional feature only)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
wr_req  in  1  user write request; level, held until wr_ack
wr_addr  in  8  user write address; stable while wr_req=1
wr_data  in  8  user write data; stable while wr_req=1
wr_ack  out  1  one-cycle pulse on the last clock of the write data phase
EN_signals  out  1  enable to signals_rtc; 1 during every phase
read  out  1  to signals_rtc; 1 only during a read data phase
dato  out  1  to signals_rtc; 0 = address phase, 1 = data phase
bus_out  out  8  value driven on the A/D bus
bus_oe  out  1  A/D bus output enable; 0 during a read data phase
bus_in  in  8  A/D bus sampled value
seg  out  8  captured seconds
min  out  8  captured minutes
hora  out  8  captured hours
time_valid  out  1  one-cycle pulse after the hours capture completes
busy  out  1  1 whenever state is not IDLE
init_done  out  1  init sequence finished (see Optional Feature)

Behaviour:
- Reset values: all outputs 0, except bus_oe=1 and init_done=1 when RTC_INIT_EN is undefined. State=IDLE, counters=0, refresh_pend=0. Reset is asynchronous and may arrive mid-transaction; the bus is abandoned with no completion pulse.
- Refresh timer:
  - Free-running 0..REFRESH_CYCLES-1.
  - On wrap it sets the sticky refresh_pend.
  - A wrap while refresh_pend is already 1 is dropped, not counted.
- States: IDLE, ADDR, DATA, GAP. A phase counter pc runs 0..PHASE_CYCLES-1 in ADDR and DATA, and 0..GAP_CYCLES-1 in GAP.
- IDLE:
  - If wr_req=1, start a write: ADDR next cycle.
  - Else if refresh_pend=1, start a refresh burst with index i=0 and clear refresh_pend.
  - If both are present in the same cycle, the write wins and refresh_pend stays set.
- ADDR:
  - EN_signals=1, dato=0, read=0, bus_oe=1.
  - bus_out = wr_addr for a write, or READ_BASE_ADDR+i for a refresh.
  - At pc=PHASE_CYCLES-1: go to DATA.
- DATA:
  - EN_signals=1, dato=1.
  - Write: read=0, bus_oe=1, bus_out=wr_data; wr_ack=1 at pc=PHASE_CYCLES-1.
  - Refresh: read=1, bus_oe=0, bus_out=0. At pc=PHASE_CYCLES-1, bus_in is captured into seg (i=0), min (i=1) or hora (i=2).
  - At pc=PHASE_CYCLES-1: go to GAP.
- GAP:
  - EN_signals=0, dato=0, read=0, bus_oe=1.
  - At end of GAP:
    - refresh with i<2: i++ and go to ADDR; the burst is atomic and a write waits;
    - refresh with i=2: pulse time_valid for 1 cycle in the first IDLE cycle;
    - otherwise: go to IDLE.
- Latency:
  - Write: wr_req sampled in IDLE to wr_ack = 2*PHASE_CYCLES clocks.
  - Refresh burst: 3*(2*PHASE_CYCLES+GAP_CYCLES) clocks.
- Registered outputs only; no combinational path from any input to any output.
- seg/min/hora hold their value until the next capture.

Optional Feature:
- Macro: RTC_INIT_EN.
- Defined:
  - After reset deassert, before any arbitration, one write of INIT_DATA to INIT_ADDR runs with the normal ADDR/DATA/GAP timing.
  - wr_ack is not pulsed for this write.
  - init_done rises at the end of its GAP and stays 1 until the next reset.
  - wr_req and refresh_pend are held off until init_done=1; the refresh timer still runs.
- Undefined: no init write; init_done is a constant 1.

Test Plan:
- Reset held 10 cycles, then released with no requests until the first refresh → the first 320 ns: EN_signals=0, bus_oe=1, seg/min/hora=0, busy=0.
- wr_req=1, wr_addr=8'h21, wr_data=8'h45 →
  - 32 clocks dato=0, bus_out=8'h21;
  - then 32 clocks dato=1, read=0, bus_out=8'h45;
  - wr_ack pulses at clock 64;
  - then 4 clocks EN_signals=0.
- REFRESH_CYCLES=200 with bus_in modelled as 8'h30/8'h15/8'h09 per address →
  - three address/read-data pairs on addresses 21, 22, 23;
  - read=1 and bus_oe=0 in data phases;
  - seg=30, min=15, hora=09; one time_valid pulse.
- wr_req asserted the same cycle refresh_pend sets → the write executes first, then the refresh burst starts immediately after its GAP.
- wr_req asserted mid-refresh-burst → the burst finishes all 3 reads before the write ADDR phase begins.
- Reset asserted at pc=10 of a DATA phase → EN_signals=0 asynchronously, state IDLE, no wr_ack.
- With RTC_INIT_EN defined → the first transaction after reset is addr 8'h02 / data 8'h10 and init_done=1 after 68 clocks. Without it, init_done=1 from reset.

Source files
------------

// File: rtl/rtc_bus_scheduler_if.sv
// rtc_bus_scheduler_if
//   Bundles the scheduler's user write port, the signals_rtc control/bus lines
//   and the captured time outputs.
//
//   Handshake (user write port): the requester raises wr_req together with a
//   stable wr_addr/wr_data and holds all three until it sees wr_ack high for
//   one clock (the last clock of the write data phase). It may drop wr_req in
//   the cycle wr_ack is seen; wr_req is only sampled while the scheduler is idle.
//
//   Modports:
//     slave  - the scheduler (rtc_bus_scheduler)
//     master - the environment driving writes and modelling the A/D bus
//
//   Signals:
//     wr_req/wr_addr/wr_data  user write request, address, data
//     wr_ack                  write completion pulse
//     EN_signals/read/dato    controls to signals_rtc
//     bus_out/bus_oe/bus_in   multiplexed A/D bus value, output enable, sample
//     seg/min/hora            captured seconds/minutes/hours
//     time_valid              one-cycle pulse after a completed time refresh
//     busy                    scheduler not idle
//     init_done               init write finished (constant 1 without RTC_INIT_EN)
//     state_dbg               current scheduler state (IDLE=0, ADDR=1, DATA=2, GAP=3)
interface rtc_bus_scheduler_if;
    logic       wr_req;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ack;
    logic       EN_signals;
    logic       read;
    logic       dato;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic [7:0] bus_in;
    logic [7:0] seg;
    logic [7:0] min;
    logic [7:0] hora;
    logic       time_valid;
    logic       busy;
    logic       init_done;
    logic [1:0] state_dbg;

    modport slave (
        input  wr_req, wr_addr, wr_data, bus_in,
        output wr_ack, EN_signals, read, dato, bus_out, bus_oe,
               seg, min, hora, time_valid, busy, init_done, state_dbg
    );

    modport master (
        output wr_req, wr_addr, wr_data, bus_in,
        input  wr_ack, EN_signals, read, dato, bus_out, bus_oe,
               seg, min, hora, time_valid, busy, init_done, state_dbg
    );
endinterface

// File: rtl/rtc_bus_scheduler.sv
// rtc_bus_scheduler
//   Sequencer/arbiter in front of the signals_rtc bus-signal generator. Two
//   requesters share the multiplexed RTC A/D bus:
//     - a periodic refresh engine that burst-reads seconds, minutes and hours
//       (READ_BASE_ADDR, +1, +2) and captures them into seg/min/hora;
//     - a user write port (wr_req/wr_addr/wr_data, completed by wr_ack).
//   Every transaction is an address phase (PHASE_CYCLES clocks), a data phase
//   (PHASE_CYCLES clocks) and a gap (GAP_CYCLES clocks with EN_signals=0).
//   A refresh burst is three back-to-back transactions and cannot be split.
//
//   Optional feature, macro RTC_INIT_EN: when defined, one write of INIT_DATA
//   to INIT_ADDR runs right after reset, before any arbitration; init_done
//   rises at the end of its gap. When undefined, init_done is constant 1.
//
//   Ports:
//     clk    system clock
//     reset  asynchronous, active-high reset; abandons any transaction
//     sif    rtc_bus_scheduler_if.slave (write port, bus controls, time outputs)
//
//   All outputs are registered: they are computed from the next-state values
//   so they line up exactly with the state they describe.
module rtc_bus_scheduler #(
    parameter int         PHASE_CYCLES   = 32,
    parameter int         GAP_CYCLES     = 4,
    parameter int         REFRESH_CYCLES = 1000,
    parameter logic [7:0] READ_BASE_ADDR = 8'h21,
    parameter logic [7:0] INIT_ADDR      = 8'h02,
    parameter logic [7:0] INIT_DATA      = 8'h10
) (
    input logic                 clk,
    input logic                 reset,
    rtc_bus_scheduler_if.slave  sif
);

`ifdef RTC_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    localparam int PC_MAX = (PHASE_CYCLES > GAP_CYCLES) ? PHASE_CYCLES : GAP_CYCLES;
    localparam int PC_W   = $clog2(PC_MAX + 1);
    localparam int RT_W   = $clog2(REFRESH_CYCLES + 1);

    localparam logic [PC_W-1:0] PH_LAST  = PC_W'(PHASE_CYCLES - 1);
    localparam logic [PC_W-1:0] GAP_LAST = PC_W'(GAP_CYCLES - 1);
    localparam logic [RT_W-1:0] RT_LAST  = RT_W'(REFRESH_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        KIND_WR   = 2'd0,
        KIND_RD   = 2'd1,
        KIND_INIT = 2'd2
    } kind_t;

    state_t          state, nxt_state;
    kind_t           kind, nxt_kind;
    logic [PC_W-1:0] pc, nxt_pc;
    logic [1:0]      idx, nxt_idx;
    logic [7:0]      addr_q, nxt_addr;
    logic [7:0]      data_q, nxt_data;

    logic [RT_W-1:0] rt;
    logic            rt_wrap;
    logic            refresh_pend;
    logic            start_refresh;
    logic            capture;
    logic            tv_d;
    logic            done_d;
    logic            init_done_q;

    // ------------------------------------------------------------------
    // Refresh timer: free-running, sets a sticky request on wrap. A wrap
    // that lands while a request is already pending is simply lost.
    // ------------------------------------------------------------------
    assign rt_wrap = (rt == RT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rt           <= '0;
            refresh_pend <= 1'b0;
        end else begin
            rt <= rt_wrap ? '0 : rt + 1'b1;
            if (start_refresh)
                refresh_pend <= 1'b0;
            else if (rt_wrap)
                refresh_pend <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Scheduler state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            kind   <= KIND_WR;
            pc     <= '0;
            idx    <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            state  <= nxt_state;
            kind   <= nxt_kind;
            pc     <= nxt_pc;
            idx    <= nxt_idx;
            addr_q <= nxt_addr;
            data_q <= nxt_data;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Arbitration happens only in IDLE, so a burst in
    // progress always finishes before a pending write can start.
    // ------------------------------------------------------------------
    always_comb begin
        nxt_state     = state;
        nxt_kind      = kind;
        nxt_pc        = pc;
        nxt_idx       = idx;
        nxt_addr      = addr_q;
        nxt_data      = data_q;
        start_refresh = 1'b0;
        capture       = 1'b0;
        tv_d          = 1'b0;
        done_d        = init_done_q;

        case (state)
            IDLE: begin
                nxt_pc = '0;
                if (!init_done_q) begin
                    nxt_state = ADDR;
                    nxt_kind  = KIND_INIT;
                    nxt_addr  = INIT_ADDR;
                    nxt_data  = INIT_DATA;
                end else if (sif.wr_req) begin
                    // Write wins a tie; refresh_pend stays set for later.
                    nxt_state = ADDR;
                    nxt_kind  = KIND_WR;
                    nxt_addr  = sif.wr_addr;
                    nxt_data  = sif.wr_data;
                end else if (refresh_pend) begin
                    start_refresh = 1'b1;
                    nxt_state     = ADDR;
                    nxt_kind      = KIND_RD;
                    nxt_idx       = 2'd0;
                    nxt_addr      = READ_BASE_ADDR;
                    nxt_data      = 8'h00;
                end
            end

            ADDR: begin
                if (pc == PH_LAST) begin
                    nxt_state = DATA;
                    nxt_pc    = '0;
                end else begin
                    nxt_pc = pc + 1'b1;
                end
            end

            DATA: begin
                if (pc == PH_LAST) begin
                    nxt_state = GAP;
                    nxt_pc    = '0;
                    capture   = (kind == KIND_RD);
                end else begin
                    nxt_pc = pc + 1'b1;
                end
            end

            GAP: begin
                if (pc == GAP_LAST) begin
                    nxt_pc = '0;
                    if (kind == KIND_RD && idx != 2'd2) begin
                        nxt_state = ADDR;
                        nxt_idx   = idx + 2'd1;
                        nxt_addr  = READ_BASE_ADDR + 8'(idx) + 8'd1;
                    end else begin
                        nxt_state = IDLE;
                        tv_d      = (kind == KIND_RD);
                        if (kind == KIND_INIT)
                            done_d = 1'b1;
                    end
                end else begin
                    nxt_pc = pc + 1'b1;
                end
            end

            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs, derived from the next-state values.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sif.EN_signals <= 1'b0;
            sif.read       <= 1'b0;
            sif.dato       <= 1'b0;
            sif.bus_out    <= 8'h00;
            sif.bus_oe     <= 1'b1;
            sif.wr_ack     <= 1'b0;
            sif.time_valid <= 1'b0;
            sif.busy       <= 1'b0;
            sif.seg        <= 8'h00;
            sif.min        <= 8'h00;
            sif.hora       <= 8'h00;
            init_done_q    <= ~INIT_EN;
        end else begin
            sif.EN_signals <= (nxt_state == ADDR) || (nxt_state == DATA);
            sif.dato       <= (nxt_state == DATA);
            sif.read       <= (nxt_state == DATA) && (nxt_kind == KIND_RD);
            sif.bus_oe     <= !((nxt_state == DATA) && (nxt_kind == KIND_RD));
            if (nxt_state == ADDR)
                sif.bus_out <= nxt_addr;
            else if (nxt_state == DATA && nxt_kind != KIND_RD)
                sif.bus_out <= nxt_data;
            else
                sif.bus_out <= 8'h00;
            // Init writes complete silently; only user writes are acknowledged.
            sif.wr_ack     <= (nxt_state == DATA) && (nxt_pc == PH_LAST) &&
                              (nxt_kind == KIND_WR);
            sif.time_valid <= tv_d;
            sif.busy       <= (nxt_state != IDLE);
            init_done_q    <= done_d;
            // bus_in is sampled on the edge that ends the read data phase.
            if (capture) begin
                case (idx)
                    2'd0:    sif.seg  <= sif.bus_in;
                    2'd1:    sif.min  <= sif.bus_in;
                    default: sif.hora <= sif.bus_in;
                endcase
            end
        end
    end

    assign sif.init_done = init_done_q;
    assign sif.state_dbg = state;

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
module tb_rtc_bus_scheduler;

    localparam int R = 200;

    logic clk;
    logic reset;

    rtc_bus_scheduler_if sif ();

    rtc_bus_scheduler #(
        .PHASE_CYCLES   (32),
        .GAP_CYCLES     (4),
        .REFRESH_CYCLES (R),
        .READ_BASE_ADDR (8'h21),
        .INIT_ADDR      (8'h02),
        .INIT_DATA      (8'h10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sif   (sif)
    );

    // ---------------- clock / reset / cycle counter ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc;
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    logic [15:0] exp_wr_q[$];   // {addr, data} of each expected user write
    logic [23:0] exp_tv_q[$];   // {hora, min, seg} expected per refresh burst

    int tv_cnt = 0;
    int ack_cnt = 0;
    int bursts_done = 0;
    int burst_idx = 0;
    int burst_start = -1;
    int last_wr_start = -1;
    int tv_cyc = -1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sif.time_valid) tv_cnt <= tv_cnt + 1;
        if (sif.wr_ack)     ack_cnt <= ack_cnt + 1;
    end

    // ---------------- RTC device model on the A/D bus ----------------
    logic [7:0] regs [3];
    logic [7:0] dev_addr = 8'h00;
    logic [7:0] off;

    always @(negedge clk) begin
        if (sif.EN_signals && !sif.dato) dev_addr <= sif.bus_out;
    end

    always_comb begin
        off        = dev_addr - 8'h21;
        sif.bus_in = 8'h5A;
        if (sif.read) begin
            if (off < 8'd3) sif.bus_in = regs[off[1:0]];
            else            sif.bus_in = 8'hEE;
        end
    end

    // Time register contents: new random values after every completed burst;
    // the value each burst must return is queued when it is set.
    initial begin
        for (int i = 0; i < 3; i++) regs[i] = 8'($urandom_range(0, 255));
        exp_tv_q.push_back({regs[2], regs[1], regs[0]});
        forever begin
            @(negedge clk);
            if (sif.time_valid) begin
                for (int i = 0; i < 3; i++) regs[i] = 8'($urandom_range(0, 255));
                exp_tv_q.push_back({regs[2], regs[1], regs[0]});
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        int start, alen, dlen, glen, ack_at;
        logic [7:0] a, d;
        logic [15:0] ew;
        logic [23:0] et;
        logic is_rd;
        bit aborted, ok_a, ok_d, ok_g;
        forever begin
            while (!(sif.EN_signals === 1'b1 && !reset)) @(negedge clk);
            start = cyc; aborted = 0; ok_a = 1; ok_d = 1; ok_g = 1;
            a = sif.bus_out; alen = 0;
            while (sif.EN_signals && !sif.dato && alen < 200) begin
                if (sif.bus_out != a || sif.read || !sif.bus_oe) ok_a = 0;
                alen++;
                @(negedge clk);
            end
            d = sif.bus_out; is_rd = sif.read; dlen = 0; ack_at = -1;
            while (sif.EN_signals && sif.dato && dlen < 200) begin
                if (sif.wr_ack) ack_at = dlen;
                if (sif.read != is_rd || sif.bus_oe != !is_rd ||
                    sif.bus_out != (is_rd ? 8'h00 : d)) ok_d = 0;
                dlen++;
                @(negedge clk);
            end
            if (reset) aborted = 1;
            glen = 0;
            while (!sif.EN_signals && sif.busy && glen < 100) begin
                if (sif.dato || sif.read || !sif.bus_oe) ok_g = 0;
                glen++;
                @(negedge clk);
            end
            if (reset) aborted = 1;
            if (aborted) begin
                burst_idx = 0;
            end else begin
                check("addr_len", alen, 32);
                check("data_len", dlen, 32);
                check("gap_len", glen, 4);
                check("addr_phase_sig", ok_a, 1);
                check("data_phase_sig", ok_d, 1);
                check("gap_phase_sig", ok_g, 1);
                if (!is_rd) begin
                    check("wr_atomic", burst_idx, 0);
                    check("wr_ack_pos", ack_at, 31);
                    if (exp_wr_q.size() == 0) begin
                        check("wr_unexpected", 0, 1);
                    end else begin
                        ew = exp_wr_q.pop_front();
                        check("wr_addr", a, ew[15:8]);
                        check("wr_data", d, ew[7:0]);
                    end
                    last_wr_start = start;
                    burst_idx = 0;
                end else begin
                    check("rd_addr", a, 8'h21 + burst_idx);
                    check("rd_no_ack", ack_at, -1);
                    if (burst_idx == 0) burst_start = start;
                    if (burst_idx == 2) begin
                        check("time_valid", sif.time_valid, 1);
                        if (exp_tv_q.size() == 0) begin
                            check("tv_unexpected", 0, 1);
                        end else begin
                            et = exp_tv_q.pop_front();
                            check("time_regs", {sif.hora, sif.min, sif.seg}, et);
                        end
                        tv_cyc = cyc;
                        bursts_done++;
                        burst_idx = 0;
                    end else begin
                        burst_idx++;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        int n = 0;
        exp_wr_q.push_back({a, d});
        sif.wr_addr = a;
        sif.wr_data = d;
        sif.wr_req  = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!sif.wr_ack && n < 2000);
        check("wr_ack_seen", sif.wr_ack, 1);
        sif.wr_req = 1'b0;
    endtask

    task automatic wait_tv(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sif.time_valid && n < budget);
        check("tv_seen", sif.time_valid, 1);
    endtask

    task automatic wait_read(input int budget);
        int n = 0;
        while (!sif.read && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("read_seen", sif.read, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int n;
        int acks_before;
        bit idle_ok;
        reset       = 1'b1;
        sif.wr_req  = 1'b0;
        sif.wr_addr = 8'h00;
        sif.wr_data = 8'h00;

        repeat (10) @(negedge clk);
        check("rst_en", sif.EN_signals, 0);
        check("rst_oe", sif.bus_oe, 1);
        check("rst_busy", sif.busy, 0);
        check("rst_read", sif.read, 0);
        check("rst_dato", sif.dato, 0);
        check("rst_bus_out", sif.bus_out, 0);
        check("rst_wr_ack", sif.wr_ack, 0);
        check("rst_tv", sif.time_valid, 0);
        check("rst_time", {sif.hora, sif.min, sif.seg}, 0);
        check("rst_init_done", sif.init_done, 1);
        check("rst_state", sif.state_dbg, 0);

        reset = 1'b0;
        idle_ok = 1;
        repeat (32) begin
            @(negedge clk);
            if (sif.EN_signals || !sif.bus_oe || sif.busy ||
                sif.seg != 0 || sif.min != 0 || sif.hora != 0) idle_ok = 0;
        end
        check("idle_after_reset", idle_ok, 1);

        // First refresh: timer wraps at edge R, burst starts at edge R+1.
        wait_tv(1000);
        check("first_burst_start", burst_start, R + 1);

        do_write(8'h21, 8'h45);

        // Write requested in the middle of a burst waits for the whole burst.
        wait_read(1000);
        do_write(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        repeat (8) @(negedge clk);
        check("write_after_burst", last_wr_start, tv_cyc + 1);

        for (int k = 0; k < 10; k++) begin
            repeat ($urandom_range(0, 250)) @(negedge clk);
            do_write(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        // Reset in the middle of a write data phase.
        exp_wr_q.push_back({8'h5C, 8'h3E});
        sif.wr_addr = 8'h5C;
        sif.wr_data = 8'h3E;
        sif.wr_req  = 1'b1;
        n = 0;
        while (!(sif.EN_signals && sif.dato && !sif.read) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("wr_data_phase_seen", sif.dato, 1);
        repeat (10) @(negedge clk);
        acks_before = ack_cnt;
        #2 reset = 1'b1;
        #1;
        check("async_rst_en", sif.EN_signals, 0);
        check("async_rst_busy", sif.busy, 0);
        check("async_rst_state", sif.state_dbg, 0);
        check("async_rst_time", {sif.hora, sif.min, sif.seg}, 0);
        sif.wr_req = 1'b0;
        exp_wr_q.delete();
        repeat (5) @(negedge clk);
        check("no_ack_on_reset", ack_cnt, acks_before);
        reset = 1'b0;

        // Write arriving in the cycle the refresh request is pending.
        n = 0;
        while (cyc != R && n < 1000) begin
            @(negedge clk);
            n++;
        end
        do_write(8'h07, 8'h99);
        wait_tv(1000);
        check("tie_write_start", last_wr_start, R + 1);
        check("tie_burst_start", burst_start, R + 70);

        repeat (5) @(negedge clk);
        check("tv_pulse_count", tv_cnt, bursts_done);
        check("wr_queue_empty", exp_wr_q.size(), 0);
        check("tv_queue_level", exp_tv_q.size(), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
